// File: rtl/flippy_pkg.sv
// Shared encodings and constants for the serial score-to-BCD converter.
package flippy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_add3_digit
    import flippy_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    // A digit of at most 9 becomes at most 12, so the 4-bit sum cannot wrap.
    always_comb begin
        adjusted = digit;
        if (digit >= ADD3_THRESHOLD)
            adjusted = digit + BCD_DIGIT_W'(3);
    end

endmodule

// File: rtl/score_bcd_serial.sv
// Multi-cycle double-dabble conversion of the binary score into held BCD digits
// with a leading-zero blank mask for the seven-segment drivers.
module score_bcd_serial
    import flippy_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clock,
    input  logic                          reset_signal,
    input  logic [WIDTH-1:0]              score,
    input  logic                          start,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]             blank,
    output logic                          busy,
    output logic                          done
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Digit i is blank when it and every more significant digit are zero;
    // the ones digit always shows.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] digits);
        logic [DIGITS-1:0] mask;
        logic              zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (digits[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            mask[i]    = zero_above;
        end
        return mask;
    endfunction

    localparam logic [DIGITS-1:0] BLANK_ZERO = blank_mask('0);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   last_score;
    logic [WIDTH-1:0]   bin_sr;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   count;
    logic               trigger;

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit    (scratch[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (scratch_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        trigger    = start | (score != last_score);
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = SHIFT;
            SHIFT:   if (count == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and visible outputs: cleared immediately by reset, so an aborted
    // conversion never produces a done pulse.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            state      <= IDLE;
            last_score <= '0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            blank      <= BLANK_ZERO;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == DONE);
            if (state == IDLE && trigger) begin
                last_score <= score;
                count      <= CNT_W'(WIDTH);
            end else if (state == SHIFT) begin
                count <= count - CNT_W'(1);
            end
            if (state == DONE) begin
                bcd   <= scratch;
                blank <= blank_mask(scratch);
            end
        end
    end

    // Conversion datapath: only meaningful between capture and DONE, so no reset.
    always_ff @(posedge clock) begin
        if (state == IDLE && trigger) begin
            bin_sr  <= score;
            scratch <= '0;
        end else if (state == SHIFT) begin
            {scratch, bin_sr} <= {scratch_adj, bin_sr} << 1;
        end
    end

endmodule

// File: tb/tb_score_bcd_serial.sv
// Self-checking bench for score_bcd_serial: vector table, directed corner
// sequences and a randomized run against a cycle-level behavioural model.
module tb_score_bcd_serial;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int LAT    = WIDTH + 1;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    if (pow10(DIGITS) <= (2 ** WIDTH) - 1) begin : g_param_bad
        initial begin
            $display("FAIL param_check: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
            $fatal(1);
        end
    end

    logic              clock;
    logic              reset_signal;
    logic [WIDTH-1:0]  score;
    logic              start;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0] blank;
    logic              busy;
    logic              done;

    int total;
    int bad;

    score_bcd_serial #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clock        (clock),
        .reset_signal (reset_signal),
        .score        (score),
        .start        (start),
        .bcd          (bcd),
        .blank        (blank),
        .busy         (busy),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  score;
        logic [11:0] exp_bcd;
        logic [2:0]  exp_blank;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bounded wait for the next done pulse, sampled on falling edges.
    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("wait_done", 32'(seen), 32'd1);
    endtask

    // Apply a new score from IDLE and check exact busy/done timing and held output.
    task automatic run_conv(input vec_t v, input logic [11:0] prev);
        score = v.score;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clock);
            check($sformatf("busy_k%0d_s%0d", k, v.score), 32'(busy), 32'd1);
            check($sformatf("nodone_k%0d_s%0d", k, v.score), 32'(done), 32'd0);
            check($sformatf("hold_k%0d_s%0d", k, v.score), 32'(bcd), 32'(prev));
        end
        @(negedge clock);
        check($sformatf("done_s%0d", v.score), 32'(done), 32'd1);
        check($sformatf("busy_end_s%0d", v.score), 32'(busy), 32'd0);
        check($sformatf("bcd_s%0d", v.score), 32'(bcd), 32'(v.exp_bcd));
        check($sformatf("blank_s%0d", v.score), 32'(blank), 32'(v.exp_blank));
        @(negedge clock);
        check($sformatf("done_once_s%0d", v.score), 32'(done), 32'd0);
    endtask

    // Behavioural reference: a conversion occupies LAT cycles, then shows the
    // decimal digits of the captured score.
    bit          m_idle;
    int          m_left;
    int          m_val;
    int          m_last;
    logic [11:0] m_bcd;
    logic [2:0]  m_blank;
    logic        m_done;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] to_blank(input int v);
        if (v < 10)  return 3'b110;
        if (v < 100) return 3'b100;
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_idle  = 1;
        m_left  = 0;
        m_val   = 0;
        m_last  = 0;
        m_bcd   = 12'h000;
        m_blank = 3'b110;
        m_done  = 0;
    endtask

    task automatic model_step(input int s, input bit st);
        m_done = 0;
        if (m_idle) begin
            if (st || s != m_last) begin
                m_last = s;
                m_val  = s;
                m_left = LAT;
                m_idle = 0;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_bcd   = to_bcd(m_val);
                m_blank = to_blank(m_val);
                m_done  = 1;
                m_idle  = 1;
            end
        end
    endtask

    initial begin
        int cnt;
        total = 0;
        bad   = 0;
        reset_signal = 1'b1;
        score = '0;
        start = 1'b0;

        vecs.push_back('{8'd173, 12'h173, 3'b000});
        vecs.push_back('{8'd255, 12'h255, 3'b000});
        vecs.push_back('{8'd7,   12'h007, 3'b110});
        vecs.push_back('{8'd0,   12'h000, 3'b110});
        vecs.push_back('{8'd10,  12'h010, 3'b100});
        vecs.push_back('{8'd100, 12'h100, 3'b000});
        vecs.push_back('{8'd9,   12'h009, 3'b110});
        vecs.push_back('{8'd200, 12'h200, 3'b000});
        vecs.push_back('{8'd5,   12'h005, 3'b110});

        // Reset state and quiet idle with score 0
        #1;
        check("rst_bcd", 32'(bcd), 32'h000);
        check("rst_blank", 32'(blank), 32'b110);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clock);
        reset_signal = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) cnt++;
        end
        check("idle_zero_activity", 32'(cnt), 32'd0);
        check("idle_zero_bcd", 32'(bcd), 32'h000);
        check("idle_zero_blank", 32'(blank), 32'b110);

        // Table of conversions, each from IDLE
        begin
            logic [11:0] prev;
            prev = 12'h000;
            foreach (vecs[i]) begin
                run_conv(vecs[i], prev);
                prev = vecs[i].exp_bcd;
            end
        end

        // Score change during shift 3 of 42: first result 42, then auto 99
        score = 8'd42;
        repeat (3) @(negedge clock);
        score = 8'd99;
        wait_done(LAT + 3);
        check("mid_first_bcd", 32'(bcd), 32'h042);
        check("mid_first_blank", 32'(blank), 32'b100);
        @(negedge clock);
        check("mid_restart_busy", 32'(busy), 32'd1);
        wait_done(LAT + 3);
        check("mid_second_bcd", 32'(bcd), 32'h099);
        check("mid_second_blank", 32'(blank), 32'b100);

        // Start with unchanged score, plus start held during busy
        score = 8'd50;
        wait_done(LAT + 3);
        check("pre50_bcd", 32'(bcd), 32'h050);
        @(negedge clock);
        check("pre50_idle", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        @(negedge clock);
        start = 1'b1;
        repeat (5) @(negedge clock);
        start = 1'b0;
        wait_done(LAT + 3);
        check("start_bcd", 32'(bcd), 32'h050);
        check("start_blank", 32'(blank), 32'b100);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (busy === 1'b1 || done === 1'b1) cnt++;
        end
        check("start_not_queued", 32'(cnt), 32'd0);

        // Reset during shift 5 of 128
        score = 8'd128;
        repeat (5) @(negedge clock);
        #2 reset_signal = 1'b1;
        #1;
        check("midrst_bcd", 32'(bcd), 32'h000);
        check("midrst_blank", 32'(blank), 32'b110);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clock);
        check("midrst_hold_done", 32'(done), 32'd0);
        reset_signal = 1'b0;
        @(negedge clock);
        check("midrst_restart_busy", 32'(busy), 32'd1);
        check("midrst_restart_nodone", 32'(done), 32'd0);
        wait_done(LAT + 3);
        check("midrst_bcd_final", 32'(bcd), 32'h128);
        check("midrst_blank_final", 32'(blank), 32'b000);

        // Randomized run against the behavioural model
        @(negedge clock);
        reset_signal = 1'b1;
        score = '0;
        start = 1'b0;
        @(negedge clock);
        reset_signal = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) score = 8'($urandom_range(0, 255));
            start = ($urandom_range(0, 9) == 0);
            model_step(int'(score), start);
            @(negedge clock);
            check("rnd_bcd", 32'(bcd), 32'(m_bcd));
            check("rnd_blank", 32'(blank), 32'(m_blank));
            check("rnd_busy", 32'(busy), 32'(!m_idle));
            check("rnd_done", 32'(done), 32'(m_done));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_bcd_serial.md
Name: score_bcd_serial

Overview:
- Sequential double-dabble converter between Big_State_Machine and the score Seven_Seg digit drivers.
- Watches the binary score. On any change, or on an explicit start, it converts the score to BCD over several clock cycles.
- Holds the last completed result steady on its outputs, so HEX2/HEX3/LEDG never show a half-converted value.
- Also produces a leading-zero blank mask so the seven-segment digits can suppress leading zeros.

Parameters:
- WIDTH, 8: width of the binary score input.
- DIGITS, 3: number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH-1; the bench checks this at elaboration.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset_signal  in  1  asynchronous, active-high reset.
- score  in  WIDTH  binary score from Big_State_Machine; may change on any cycle.
- start  in  1  forces a reconversion of the current score when sampled high in IDLE.
- bcd  out  4*DIGITS  packed BCD digits; [3:0]=ones, [7:4]=tens, [11:8]=hundreds.
- blank  out  DIGITS  bit i=1 means digit i is a leading zero; bit 0 is always 0.
- busy  out  1  high while a conversion is in flight.
- done  out  1  one-cycle pulse, coincident with the first cycle in which a new bcd value is visible.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: bcd=0, blank={DIGITS-1{1},0}, busy=0, done=0.
  - Internal: state=IDLE, last_score=0, shift count=0.
- FSM states: IDLE, SHIFT, DONE. busy = (state != IDLE), registered.
- IDLE:
  - Trigger = start | (score != last_score).
  - On trigger: capture score into the binary shift register, set last_score<=score, clear the BCD scratch register, set count<=WIDTH, go to SHIFT.
  - Otherwise hold.
- SHIFT, one iteration per edge:
  - Every scratch digit >=5 gets +3, in parallel.
  - Then {scratch,binary} shifts left by 1.
  - count decrements; after the iteration where count goes 1->0, go to DONE.
- DONE, one edge:
  - bcd<=scratch; blank recomputed from scratch; done<=1 for the following cycle; return to IDLE.
  - done is 0 on all other cycles.
- Latency, with the capture edge as edge 0:
  - Shifts occur on edges 1..WIDTH.
  - Outputs load on edge WIDTH+1 (edge 9 for the defaults).
  - busy is high for exactly WIDTH+1 cycles.
- Score changes while busy: ignored until IDLE. last_score then differs, so a fresh conversion starts on the first IDLE edge. Intermediate values may be skipped; the final value always converges.
- start while busy: ignored (not queued).
- start together with a score change in IDLE: a single conversion.
- Back-to-back conversions: the IDLE dwell is 1 cycle minimum.
- Blank rule, evaluated from the most-significant digit downward: digit i (i>0) is blanked iff it and every higher digit is 0. Score 0 gives blank=3'b110.
- Arithmetic: the add-3 result is 4 bits and never overflows, since a digit >=5 becomes <=12 before the shift. No saturation logic is needed when the parameters are legal.
- Reset asserted mid-conversion: everything returns to reset values immediately, and no done pulse is issued.
  - After release, a nonzero score differs from last_score=0, so a conversion auto-starts on the first edge.
  - Score 0 needs no conversion; the reset outputs already represent 0.

Decomposition:
- Package flippy_pkg holds:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - BCD_DIGIT_W=4;
  - the add-3 threshold constant (5).
- Sub-module bcd_add3_digit: combinational, 4-bit in, 4-bit out, adds 3 when the input is >=5. Instantiated DIGITS times via generate.
- The FSM, counter and output registers stay in score_bcd_serial.

Test Plan:
- Reset then release with score=0:
  - bcd=12'h000, blank=3'b110, busy=0.
  - No done pulse within 20 cycles.
- score 0->8'd173 in IDLE:
  - busy high for 9 cycles.
  - done pulses on the 10th cycle with bcd=12'h173, blank=3'b000.
- score=8'd255, then 8'd7:
  - First result 12'h255 / blank 3'b000.
  - Second result 12'h007 / blank 3'b110.
  - bcd holds 12'h255 until the done for 7.
- While busy converting 8'd42, change score to 8'd99 on shift cycle 3:
  - First done shows 12'h042.
  - Reconversion starts automatically; second done shows 12'h099, blank 3'b100.
- Pulse start with score unchanged at 8'd50:
  - One conversion, done with bcd=12'h050.
  - A start held high during busy produces no extra conversion.
- Assert reset on shift cycle 5 of converting 8'd128, release with score=8'd128:
  - Outputs go to reset values immediately, with no done pulse.
  - Conversion restarts; done shows 12'h128, blank 3'b000.
